// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: drains two FIFO-style sources into one registered output
// stream using round-robin arbitration with a per-source burst limit.
// Optional feature macro: FIFO_ARB_CNT_EN. When it is defined, the per-source
// grant counters CNT0/CNT1 are built. When it is undefined, both are tied to zero.
module fifo_drain_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             S0_EMPTY_N,
  input  logic [WIDTH-1:0] S0_D_OUT,
  output logic             S0_DEQ,
  input  logic             S1_EMPTY_N,
  input  logic [WIDTH-1:0] S1_D_OUT,
  output logic             S1_DEQ,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_SRC,
  input  logic             OUT_READY,
  output logic [CNT_W-1:0] CNT0,
  output logic [CNT_W-1:0] CNT1
);

  // The burst counter saturates at BURST_MAX, so it needs enough bits to hold BURST_MAX itself.
  localparam int BW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);
  localparam logic [BW-1:0] BURST_ONE = BW'(1);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_src_q,   out_src_d;
  logic             owner_q,     owner_d;
  logic [BW-1:0]    burst_q,     burst_d;

  logic load_s;
  logic grant_s;
  logic grant_src_s;

  // Grant decision: choose which source, if any, is dequeued in this cycle.
  always_comb begin
    load_s      = !out_valid_q || OUT_READY;
    grant_s     = 1'b0;
    grant_src_s = 1'b0;
    if (RST || CLR || !load_s) begin
      grant_s     = 1'b0;
      grant_src_s = 1'b0;
    end else if (S0_EMPTY_N && S1_EMPTY_N) begin
      // Both sources are requesting. The owner keeps the grant until its burst is used up.
      grant_s     = 1'b1;
      grant_src_s = (burst_q < BURST_LIM) ? owner_q : ~owner_q;
    end else if (S0_EMPTY_N) begin
      grant_s     = 1'b1;
      grant_src_s = 1'b0;
    end else if (S1_EMPTY_N) begin
      grant_s     = 1'b1;
      grant_src_s = 1'b1;
    end else begin
      grant_s     = 1'b0;
      grant_src_s = 1'b0;
    end
  end

  // A DEQ strobe is only raised on a grant, and a grant needs that source's EMPTY_N.
  assign S0_DEQ = grant_s & ~grant_src_s;
  assign S1_DEQ = grant_s &  grant_src_s;

  // Next state for the output register and the burst tracking.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    owner_d     = owner_q;
    burst_d     = burst_q;
    if (grant_s) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_src_s ? S1_D_OUT : S0_D_OUT;
      out_src_d   = grant_src_s;
      if (grant_src_s == owner_q) begin
        burst_d = (burst_q == BURST_LIM) ? BURST_LIM : (burst_q + BURST_ONE);
      end else begin
        owner_d = grant_src_s;
        burst_d = BURST_ONE;
      end
    end else if (load_s) begin
      // Either the register was already empty or its word was consumed this cycle.
      out_valid_d = 1'b0;
    end else begin
      // Downstream is stalling, so hold the current word.
      out_valid_d = out_valid_q;
    end
  end

  // State registers. Reset and flush have the same effect.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      out_src_q   <= 1'b0;
      owner_q     <= 1'b0;
      burst_q     <= {BW{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      owner_q     <= owner_d;
      burst_q     <= burst_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_SRC   = out_src_q;

`ifdef FIFO_ARB_CNT_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Per-source grant counters. They wrap naturally modulo 2^CNT_W.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      cnt0_q <= {CNT_W{1'b0}};
      cnt1_q <= {CNT_W{1'b0}};
    end else begin
      if (S0_DEQ) begin
        cnt0_q <= cnt0_q + CNT_W'(1);
      end else begin
        cnt0_q <= cnt0_q;
      end
      if (S1_DEQ) begin
        cnt1_q <= cnt1_q + CNT_W'(1);
      end else begin
        cnt1_q <= cnt1_q;
      end
    end
  end

  assign CNT0 = cnt0_q;
  assign CNT1 = cnt1_q;
`else
  assign CNT0 = {CNT_W{1'b0}};
  assign CNT1 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed testbench for fifo_drain_arbiter (WIDTH=8, BURST_MAX=4, CNT_W=4).
// The expected counter values depend on whether FIFO_ARB_CNT_EN is defined.
module tb_fifo_drain_arbiter;

`ifdef FIFO_ARB_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CLR = 1'b0;
  logic       S0_EMPTY_N = 1'b0;
  logic [7:0] S0_D_OUT = 8'h00;
  logic       S0_DEQ;
  logic       S1_EMPTY_N = 1'b0;
  logic [7:0] S1_D_OUT = 8'h00;
  logic       S1_DEQ;
  logic       OUT_VALID;
  logic [7:0] OUT_DATA;
  logic       OUT_SRC;
  logic       OUT_READY = 1'b0;
  logic [3:0] CNT0;
  logic [3:0] CNT1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       deq0_s;
  logic       deq1_s;

  fifo_drain_arbiter #(.WIDTH(8), .BURST_MAX(4), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR),
    .S0_EMPTY_N(S0_EMPTY_N), .S0_D_OUT(S0_D_OUT), .S0_DEQ(S0_DEQ),
    .S1_EMPTY_N(S1_EMPTY_N), .S1_D_OUT(S1_D_OUT), .S1_DEQ(S1_DEQ),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_SRC(OUT_SRC),
    .OUT_READY(OUT_READY), .CNT0(CNT0), .CNT1(CNT1)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] cnt_exp(input int n);
    return CNT_ON ? 4'(n) : 4'd0;
  endfunction

  // One clock: present the queue heads, sample the DEQ strobes before the edge,
  // and then pop the heads the DUT dequeued. The task returns 1 time unit after the edge.
  task automatic cycle();
    S0_EMPTY_N = (q0.size() > 0);
    S0_D_OUT   = (q0.size() > 0) ? q0[0] : 8'h00;
    S1_EMPTY_N = (q1.size() > 0);
    S1_D_OUT   = (q1.size() > 0) ? q1[0] : 8'h00;
    #3;
    deq0_s = S0_DEQ;
    deq1_s = S1_DEQ;
    @(posedge CLK);
    #1;
    if (deq0_s && q0.size() > 0) q0.delete(0);
    if (deq1_s && q1.size() > 0) q1.delete(0);
  endtask

  task automatic clr_pulse();
    CLR = 1'b1;
    cycle();
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    S0_EMPTY_N = 1'b1; S0_D_OUT = 8'h5A;
    S1_EMPTY_N = 1'b1; S1_D_OUT = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      #3;
      n_cmp++;
      if ({S0_DEQ, S1_DEQ} !== 2'b00) begin
        n_fail++; $display("FAIL reset_deq cyc%0d: got %b want 00", i, {S0_DEQ, S1_DEQ});
      end
      @(posedge CLK);
      #1;
    end
    n_cmp++;
    if ({OUT_VALID, OUT_DATA, OUT_SRC} !== 10'd0) begin
      n_fail++; $display("FAIL reset_out: got v=%b d=%h s=%b want 0/00/0", OUT_VALID, OUT_DATA, OUT_SRC);
    end
    n_cmp++;
    if ({CNT0, CNT1} !== 8'h00) begin
      n_fail++; $display("FAIL reset_cnt: got %h/%h want 0/0", CNT0, CNT1);
    end
    RST = 1'b0;
    S0_EMPTY_N = 1'b0;
    S1_EMPTY_N = 1'b0;
  endtask

  task automatic test_single_source();
    logic [7:0] exp_d [3];
    exp_d = '{8'h11, 8'h22, 8'h33};
    q0 = '{8'h11, 8'h22, 8'h33};
    OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (!(OUT_VALID === 1'b1 && OUT_DATA === exp_d[i] && OUT_SRC === 1'b0 && deq1_s === 1'b0)) begin
        n_fail++;
        $display("FAIL single_word%0d: got v=%b d=%h s=%b deq1=%b want 1/%h/0/0",
                 i, OUT_VALID, OUT_DATA, OUT_SRC, deq1_s, exp_d[i]);
      end
    end
    cycle();
    n_cmp++;
    if (OUT_VALID !== 1'b0 || deq0_s !== 1'b0 || deq1_s !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got v=%b deq=%b%b want 0/00", OUT_VALID, deq0_s, deq1_s);
    end
    n_cmp++;
    if (CNT0 !== cnt_exp(3) || CNT1 !== 4'd0) begin
      n_fail++; $display("FAIL single_cnt: got %0d/%0d want %0d/0", CNT0, CNT1, cnt_exp(3));
    end
  endtask

  task automatic test_burst_rr();
    logic [7:0] exp_d [12];
    logic       exp_s [12];
    exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hA4, 8'hA5, 8'hB4, 8'hB5};
    exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    clr_pulse();
    q0 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    q1 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    OUT_READY = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      n_cmp++;
      if (!(OUT_VALID === 1'b1 && OUT_DATA === exp_d[i] && OUT_SRC === exp_s[i])) begin
        n_fail++;
        $display("FAIL burst_word%0d: got v=%b d=%h s=%b want 1/%h/%b",
                 i, OUT_VALID, OUT_DATA, OUT_SRC, exp_d[i], exp_s[i]);
      end
    end
    cycle();
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL burst_drain: got v=%b want 0", OUT_VALID);
    end
    n_cmp++;
    if (CNT0 !== cnt_exp(6) || CNT1 !== cnt_exp(6)) begin
      n_fail++; $display("FAIL burst_cnt: got %0d/%0d want %0d/%0d", CNT0, CNT1, cnt_exp(6), cnt_exp(6));
    end
  endtask

  task automatic test_backpressure();
    clr_pulse();
    q0 = '{8'hA0, 8'hA1, 8'hA2};
    OUT_READY = 1'b1;
    cycle();
    cycle();
    n_cmp++;
    if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'hA1) begin
      n_fail++; $display("FAIL bp_setup: got v=%b d=%h want 1/a1", OUT_VALID, OUT_DATA);
    end
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++;
      if (!(OUT_VALID === 1'b1 && OUT_DATA === 8'hA1 && OUT_SRC === 1'b0 && deq0_s === 1'b0 && deq1_s === 1'b0)) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b d=%h s=%b deq=%b%b want 1/a1/0/00",
                 i, OUT_VALID, OUT_DATA, OUT_SRC, deq0_s, deq1_s);
      end
    end
    OUT_READY = 1'b1;
    cycle();
    n_cmp++;
    if (!(deq0_s === 1'b1 && OUT_VALID === 1'b1 && OUT_DATA === 8'hA2)) begin
      n_fail++; $display("FAIL bp_release: got deq0=%b v=%b d=%h want 1/1/a2", deq0_s, OUT_VALID, OUT_DATA);
    end
    cycle();
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: got v=%b want 0", OUT_VALID);
    end
  endtask

  task automatic test_clr_midstream();
    logic [7:0] exp_d [3];
    logic       exp_s [3];
    exp_d = '{8'h03, 8'h81, 8'h82};
    exp_s = '{1'b0, 1'b1, 1'b1};
    clr_pulse();
    q0 = '{8'h01, 8'h02, 8'h03};
    q1 = '{8'h81, 8'h82};
    OUT_READY = 1'b1;
    cycle();
    cycle();
    n_cmp++;
    if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h02) begin
      n_fail++; $display("FAIL clr_setup: got v=%b d=%h want 1/02", OUT_VALID, OUT_DATA);
    end
    CLR = 1'b1;
    cycle();
    CLR = 1'b0;
    n_cmp++;
    if (deq0_s !== 1'b0 || deq1_s !== 1'b0) begin
      n_fail++; $display("FAIL clr_deq: got %b%b want 00", deq0_s, deq1_s);
    end
    n_cmp++;
    if (OUT_VALID !== 1'b0 || CNT0 !== 4'd0 || CNT1 !== 4'd0) begin
      n_fail++; $display("FAIL clr_state: got v=%b cnt=%0d/%0d want 0/0/0", OUT_VALID, CNT0, CNT1);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (!(OUT_VALID === 1'b1 && OUT_DATA === exp_d[i] && OUT_SRC === exp_s[i])) begin
        n_fail++;
        $display("FAIL clr_after%0d: got v=%b d=%h s=%b want 1/%h/%b",
                 i, OUT_VALID, OUT_DATA, OUT_SRC, exp_d[i], exp_s[i]);
      end
    end
    n_cmp++;
    if (CNT0 !== cnt_exp(1) || CNT1 !== cnt_exp(2)) begin
      n_fail++; $display("FAIL clr_cnt: got %0d/%0d want %0d/%0d", CNT0, CNT1, cnt_exp(1), cnt_exp(2));
    end
    cycle();
  endtask

  task automatic test_counter_wrap();
    clr_pulse();
    for (int i = 0; i < 17; i++) q1.push_back(8'h40 + 8'(i));
    OUT_READY = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cycle();
      n_cmp++;
      if (!(OUT_VALID === 1'b1 && OUT_DATA === (8'h40 + 8'(i)) && OUT_SRC === 1'b1 &&
            CNT1 === cnt_exp(i + 1) && CNT0 === 4'd0)) begin
        n_fail++;
        $display("FAIL wrap%0d: got v=%b d=%h s=%b cnt=%0d/%0d want 1/%h/1 cnt 0/%0d",
                 i, OUT_VALID, OUT_DATA, OUT_SRC, CNT0, CNT1, 8'h40 + 8'(i), cnt_exp(i + 1));
      end
    end
    cycle();
    n_cmp++;
    if (OUT_VALID !== 1'b0 || CNT1 !== cnt_exp(1)) begin
      n_fail++; $display("FAIL wrap_final: got v=%b cnt1=%0d want 0/%0d", OUT_VALID, CNT1, cnt_exp(1));
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_source();
    test_burst_rr();
    test_backpressure();
    test_clr_midstream();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
